// File: rtl/bcd_display_scheduler.sv
// bcd_display_scheduler
// Shares one external 6-bit binary-to-BCD converter between a score (A) and a
// countdown timer (B). Every sample tick both values are snapshotted and run
// through the converter back to back. The four captured BCD digits are
// scanned onto a 4-digit common-anode display (active-low anodes).
module bcd_display_scheduler #(
  parameter int SCAN_DIV   = 100000,
  parameter int SAMPLE_DIV = 5000000,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] val_a,
  input  logic [5:0] val_b,
  input  logic       freeze,
  output logic [5:0] conv_bin,
  input  logic [3:0] conv_ones,
  input  logic [3:0] conv_tens,
  output logic       busy,
  output logic       upd_done,
  output logic [3:0] an,
  output logic [3:0] digit
);

  localparam int SAMPLE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);
  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAP_A = 2'd1,
    CAP_B = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          conv_bin_q, conv_bin_d;
  logic [5:0]          snap_b_q, snap_b_d;
  logic                busy_q, busy_d;
  logic                upd_done_q, upd_done_d;
  logic [7:0]          bcd_a_q, bcd_a_d;
  logic [7:0]          bcd_b_q, bcd_b_d;
  logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0]          an_q, an_d;
  logic [3:0]          digit_q, digit_d;
  logic                tick;
  logic                scan_wrap;

  // A tens digit is suppressed only when leading-zero blanking is enabled.
  function automatic logic blank_tens(input logic [3:0] tens);
    return BLANK_LZ && (tens == 4'h0);
  endfunction

  // Free-running sample and scan dividers; idx steps once per scan period.
  always_comb begin
    tick         = (sample_cnt_q == SAMPLE_LAST);
    sample_cnt_d = tick ? '0 : sample_cnt_q + SAMPLE_W'(1);
    scan_wrap    = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d        = scan_wrap ? idx_q + 2'd1 : idx_q;
  end

  // Conversion round sequencing: A goes through the converter, then B.
  always_comb begin
    state_d    = state_q;
    conv_bin_d = conv_bin_q;
    snap_b_d   = snap_b_q;
    busy_d     = busy_q;
    upd_done_d = 1'b0;
    bcd_a_d    = bcd_a_q;
    bcd_b_d    = bcd_b_q;
    case (state_q)
      IDLE: begin
        // A tick seen while frozen is simply lost; it is never queued.
        if (tick && !freeze) begin
          snap_b_d   = val_b;
          conv_bin_d = val_a;
          busy_d     = 1'b1;
          state_d    = CAP_A;
        end
      end
      CAP_A: begin
        bcd_a_d    = {conv_tens, conv_ones};
        conv_bin_d = snap_b_q;
        state_d    = CAP_B;
      end
      CAP_B: begin
        bcd_b_d    = {conv_tens, conv_ones};
        busy_d     = 1'b0;
        upd_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Digit scan: pick anode and digit for the current idx, with blanking.
  always_comb begin
    an_d    = 4'b1110;
    digit_d = bcd_b_q[3:0];
    case (idx_q)
      2'd0: begin
        an_d    = 4'b1110;
        digit_d = bcd_b_q[3:0];
      end
      2'd1: begin
        an_d    = 4'b1101;
        digit_d = bcd_b_q[7:4];
        if (blank_tens(bcd_b_q[7:4])) begin
          an_d    = 4'b1111;
          digit_d = 4'hF;
        end
      end
      2'd2: begin
        an_d    = 4'b1011;
        digit_d = bcd_a_q[3:0];
      end
      default: begin
        an_d    = 4'b0111;
        digit_d = bcd_a_q[7:4];
        if (blank_tens(bcd_a_q[7:4])) begin
          an_d    = 4'b1111;
          digit_d = 4'hF;
        end
      end
    endcase
  end

  // State, counters, captured digits and display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      conv_bin_q   <= '0;
      busy_q       <= 1'b0;
      upd_done_q   <= 1'b0;
      bcd_a_q      <= '0;
      bcd_b_q      <= '0;
      sample_cnt_q <= '0;
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      an_q         <= 4'b1110;
      digit_q      <= 4'h0;
    end else begin
      state_q      <= state_d;
      conv_bin_q   <= conv_bin_d;
      busy_q       <= busy_d;
      upd_done_q   <= upd_done_d;
      bcd_a_q      <= bcd_a_d;
      bcd_b_q      <= bcd_b_d;
      sample_cnt_q <= sample_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      digit_q      <= digit_d;
    end
  end

  // B snapshot is pure data and is only consumed after being loaded in IDLE.
  always_ff @(posedge clk) begin
    snap_b_q <= snap_b_d;
  end

  assign conv_bin = conv_bin_q;
  assign busy     = busy_q;
  assign upd_done = upd_done_q;
  assign an       = an_q;
  assign digit    = digit_q;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Testbench for bcd_display_scheduler: two instances (leading-zero blanking
// on and off) share stimulus; an arithmetic model is compared every cycle
// and directed scenarios add literal checks.
`timescale 1ns/1ps
module tb_bcd_display_scheduler;

  localparam int SCAN = 4;
  localparam int SAMP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] val_a = 6'd0;
  logic [5:0] val_b = 6'd0;
  logic       freeze = 1'b0;

  logic [5:0] cb1, cb0;
  logic [3:0] co1, ct1, co0, ct0;
  logic       busy1, busy0, upd1, upd0;
  logic [3:0] an1, dg1, an0, dg0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external binary-to-BCD converter.
  assign co1 = 4'(cb1 % 6'd10);
  assign ct1 = 4'(cb1 / 6'd10);
  assign co0 = 4'(cb0 % 6'd10);
  assign ct0 = 4'(cb0 / 6'd10);

  bcd_display_scheduler #(.SCAN_DIV(SCAN), .SAMPLE_DIV(SAMP), .BLANK_LZ(1'b1)) u_lz (
    .clk(clk), .rst(rst), .val_a(val_a), .val_b(val_b), .freeze(freeze),
    .conv_bin(cb1), .conv_ones(co1), .conv_tens(ct1),
    .busy(busy1), .upd_done(upd1), .an(an1), .digit(dg1));

  bcd_display_scheduler #(.SCAN_DIV(SCAN), .SAMPLE_DIV(SAMP), .BLANK_LZ(1'b0)) u_nz (
    .clk(clk), .rst(rst), .val_a(val_a), .val_b(val_b), .freeze(freeze),
    .conv_bin(cb0), .conv_ones(co0), .conv_tens(ct0),
    .busy(busy0), .upd_done(upd0), .an(an0), .digit(dg0));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // What the display shows for scan position idx given the two BCD pairs.
  function automatic void disp(input int idx, input logic [7:0] a, input logic [7:0] b,
                               input bit blank, output logic [3:0] an_o,
                               output logic [3:0] dg_o);
    logic [7:0] v;
    v    = (idx < 2) ? b : a;
    an_o = ~4'(1 << idx);
    dg_o = (idx % 2 == 1) ? v[7:4] : v[3:0];
    if (blank && (idx % 2 == 1) && (v[7:4] == 4'h0)) begin
      an_o = 4'hF;
      dg_o = 4'hF;
    end
  endfunction

  // Model: e = clock edges since reset; a round is tracked by its age.
  int         e = 0;
  int         age = 0;
  bit         mvalid = 1'b0;
  logic [5:0] sa, sb, m_conv;
  logic       m_busy, m_upd;
  logic [7:0] m_a, m_b;
  logic [3:0] m_an1, m_dg1, m_an0, m_dg0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        e = 0; age = 0;
        m_conv = '0; m_busy = 1'b0; m_upd = 1'b0;
        m_a = '0; m_b = '0;
        m_an1 = 4'b1110; m_dg1 = 4'h0; m_an0 = 4'b1110; m_dg0 = 4'h0;
        mvalid = 1'b1;
      end else begin
        disp((e / SCAN) % 4, m_a, m_b, 1'b1, m_an1, m_dg1);
        disp((e / SCAN) % 4, m_a, m_b, 1'b0, m_an0, m_dg0);
        m_upd = 1'b0;
        if (age == 0) begin
          if ((e % SAMP == SAMP - 1) && !freeze) begin
            sa = val_a; sb = val_b; m_conv = val_a; m_busy = 1'b1; age = 1;
          end
        end else if (age == 1) begin
          m_a = to_bcd(int'(sa)); m_conv = sb; age = 2;
        end else begin
          m_b = to_bcd(int'(sb)); m_busy = 1'b0; m_upd = 1'b1; age = 0;
        end
        e++;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("cyc_conv_bin", cb1, m_conv);
        chk("cyc_busy", busy1, m_busy);
        chk("cyc_upd_done", upd1, m_upd);
        chk("cyc_an_lz", an1, m_an1);
        chk("cyc_digit_lz", dg1, m_dg1);
        chk("cyc_conv_bin_nz", cb0, m_conv);
        chk("cyc_busy_nz", busy0, m_busy);
        chk("cyc_upd_nz", upd0, m_upd);
        chk("cyc_an_nz", an0, m_an0);
        chk("cyc_digit_nz", dg0, m_dg0);
      end
    end
  end

  task automatic wait_busy(input string nm);
    int n;
    n = 0;
    while (!busy1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy_wait"}, busy1, 1);
  endtask

  task automatic wait_upd(input string nm);
    int n;
    n = 0;
    while (!upd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_upd_wait"}, upd1, 1);
  endtask

  // Observe one full scan and confirm every expected position appears.
  task automatic scan_check(input string nm, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] ea1[4], ed1[4], ea0[4], ed0[4];
    bit f1[4], f0[4];
    bit m1, m0;
    int stray;
    for (int i = 0; i < 4; i++) begin
      disp(i, a, b, 1'b1, ea1[i], ed1[i]);
      disp(i, a, b, 1'b0, ea0[i], ed0[i]);
      f1[i] = 1'b0;
      f0[i] = 1'b0;
    end
    stray = 0;
    repeat (16) begin
      @(negedge clk);
      m1 = 1'b0;
      m0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (an1 == ea1[i] && dg1 == ed1[i]) begin f1[i] = 1'b1; m1 = 1'b1; end
        if (an0 == ea0[i] && dg0 == ed0[i]) begin f0[i] = 1'b1; m0 = 1'b1; end
      end
      if (!m1) stray++;
      if (!m0) stray++;
    end
    chk({nm, "_stray"}, stray, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_lz_pos%0d", nm, i), int'(f1[i]), 1);
      chk($sformatf("%s_nz_pos%0d", nm, i), int'(f0[i]), 1);
    end
  endtask

  int seen;

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    chk("t1_an", an1, 4'b1110);
    chk("t1_digit", dg1, 0);
    chk("t1_busy", busy1, 0);
    chk("t1_conv_bin", cb1, 0);
    chk("t1_upd_done", upd1, 0);
    val_a = 6'd42;
    val_b = 6'd7;
    rst = 1'b0;

    // 2: first round, A then B through the converter
    wait_busy("t2");
    chk("t2_conv_a", cb1, 42);
    @(negedge clk);
    chk("t2_conv_b", cb1, 7);
    @(negedge clk);
    chk("t2_upd_high", upd1, 1);
    chk("t2_model_a", m_a, 8'h42);
    chk("t2_model_b", m_b, 8'h07);
    freeze = 1'b1;
    @(negedge clk);
    chk("t2_upd_pulse", upd1, 0);
    scan_check("t2_scan", 8'h42, 8'h07);

    // 3: input change after the tick edge does not leak into the round
    freeze = 1'b0;
    wait_busy("t3a");
    val_a = 6'd13;
    wait_upd("t3a");
    chk("t3_model_a_old", m_a, 8'h42);
    freeze = 1'b1;
    scan_check("t3_scan_old", 8'h42, 8'h07);
    freeze = 1'b0;
    wait_upd("t3b");
    chk("t3_model_a_new", m_a, 8'h13);
    freeze = 1'b1;
    scan_check("t3_scan_new", 8'h13, 8'h07);

    // 4: frozen across two ticks, then released
    val_a = 6'd63;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy1) seen++;
    end
    chk("t4_busy_frozen", seen, 0);
    scan_check("t4_scan_held", 8'h13, 8'h07);
    freeze = 1'b0;
    wait_upd("t4");
    chk("t4_model_a", m_a, 8'h63);
    freeze = 1'b1;
    scan_check("t4_scan_new", 8'h63, 8'h07);

    // 5: zero timer value, blanked vs shown tens digit
    val_b = 6'd0;
    freeze = 1'b0;
    wait_upd("t5");
    freeze = 1'b1;
    chk("t5_model_b", m_b, 8'h00);
    scan_check("t5_scan", 8'h63, 8'h00);

    // 6: reset in the middle of a round
    freeze = 1'b0;
    wait_busy("t6");
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy1, 0);
    chk("t6_conv_bin", cb1, 0);
    chk("t6_upd_done", upd1, 0);
    chk("t6_an", an1, 4'b1110);
    rst = 1'b0;
    freeze = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (upd1) seen++;
    end
    chk("t6_no_upd", seen, 0);
    scan_check("t6_scan_cleared", 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
